// File: rtl/elevator_pkg.sv
// Shared constants and types for the elevator request side.
// Floor/direction/door codes and the sweep state enum.
package elevator_pkg;

    localparam int NUM_FLOOR = 7;
    localparam int FLOOR_W   = 3;

    localparam logic [FLOOR_W-1:0] FLOOR_NONE = '0;

    localparam logic [1:0] DIR_UP   = 2'b10;
    localparam logic [1:0] DIR_DN   = 2'b01;
    localparam logic [1:0] DIR_NONE = 2'b00;

    localparam logic OPEN  = 1'b1;
    localparam logic CLOSE = 1'b0;

    typedef enum logic [1:0] {
        IDLE,
        UP,
        DOWN
    } sweep_t;

endpackage

// File: rtl/elevator_call_pick.sv
// Combinational SCAN target picker over the pending call vectors.
// Ports: car/up/dn calls (floor-indexed), floor_in, state -> any_above/below/here, next_floor, next_dir.
module elevator_call_pick
    import elevator_pkg::*;
(
    input  logic [NUM_FLOOR:1] car,
    input  logic [NUM_FLOOR:1] up,
    input  logic [NUM_FLOOR:1] dn,
    input  logic [FLOOR_W-1:0] floor_in,
    input  sweep_t             state,
    output logic               any_above,
    output logic               any_below,
    output logic               any_here,
    output logic [FLOOR_W-1:0] next_floor,
    output logic [1:0]         next_dir
);

    logic [NUM_FLOOR:1] any_call;
    logic [FLOOR_W-1:0] up_lo;
    logic [FLOOR_W-1:0] up_lo_dn;
    logic [FLOOR_W-1:0] dn_hi;
    logic [FLOOR_W-1:0] dn_hi_up;
    logic [FLOOR_W-1:0] near_a;
    logic [FLOOR_W-1:0] near_b;
    logic [FLOOR_W-1:0] dist_a;
    logic [FLOOR_W-1:0] dist_b;

    assign any_call = car | up | dn;
    assign dist_a   = near_a - floor_in;
    assign dist_b   = floor_in - near_b;

    // Searches include the current floor so a call being served keeps
    // the target pinned until its clear lands.
    always_comb begin
        any_above = 1'b0;
        any_below = 1'b0;
        any_here  = 1'b0;
        up_lo     = FLOOR_NONE;
        up_lo_dn  = FLOOR_NONE;
        dn_hi     = FLOOR_NONE;
        dn_hi_up  = FLOOR_NONE;
        near_a    = FLOOR_NONE;
        near_b    = FLOOR_NONE;
        // Ascending scan: last hit is the highest floor.
        for (int i = 1; i <= NUM_FLOOR; i++) begin
            if (any_call[i] && i > int'(floor_in))
                any_above = 1'b1;
            if (any_call[i] && i == int'(floor_in))
                any_here = 1'b1;
            if (any_call[i] && i < int'(floor_in)) begin
                any_below = 1'b1;
                near_b    = FLOOR_W'(i);
            end
            if ((car[i] || dn[i]) && i <= int'(floor_in))
                dn_hi = FLOOR_W'(i);
            if (dn[i] && i >= int'(floor_in))
                dn_hi_up = FLOOR_W'(i);
        end
        // Descending scan: last hit is the lowest floor.
        for (int i = NUM_FLOOR; i >= 1; i--) begin
            if (any_call[i] && i > int'(floor_in))
                near_a = FLOOR_W'(i);
            if ((car[i] || up[i]) && i >= int'(floor_in))
                up_lo = FLOOR_W'(i);
            if (up[i] && i <= int'(floor_in))
                up_lo_dn = FLOOR_W'(i);
        end
    end

    always_comb begin
        next_floor = FLOOR_NONE;
        next_dir   = DIR_NONE;
        unique case (state)
            IDLE: begin
                // next_dir here is the sweep to start; ties go up.
                if (any_above && (!any_below || dist_a <= dist_b)) begin
                    next_floor = near_a;
                    next_dir   = DIR_UP;
                end else if (any_below) begin
                    next_floor = near_b;
                    next_dir   = DIR_DN;
                end else if (any_here) begin
                    next_floor = floor_in;
                end
            end
            UP: begin
                if (up_lo != FLOOR_NONE) begin
                    next_floor = up_lo;
                    next_dir   = DIR_UP;
                end else if (dn_hi_up != FLOOR_NONE) begin
                    next_floor = dn_hi_up;
                    next_dir   = DIR_DN;
                end
            end
            DOWN: begin
                if (dn_hi != FLOOR_NONE) begin
                    next_floor = dn_hi;
                    next_dir   = DIR_DN;
                end else if (up_lo_dn != FLOOR_NONE) begin
                    next_floor = up_lo_dn;
                    next_dir   = DIR_UP;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/elevator_call_scheduler.sv
// Latches car/hall calls, drives lamps and a registered SCAN target.
// Ports: clk, reset, CarBtn/HallUpBtn/HallDnBtn, FloorIn/DirectIn/DoorIn -> TargetFloor/TargetDirect, lamps.
module elevator_call_scheduler
    import elevator_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_FLOOR:1]   CarBtn,
    input  logic [NUM_FLOOR-1:1] HallUpBtn,
    input  logic [NUM_FLOOR:2]   HallDnBtn,
    input  logic [FLOOR_W-1:0]   FloorIn,
    input  logic [1:0]           DirectIn,
    input  logic                 DoorIn,
    output logic [FLOOR_W-1:0]   TargetFloor,
    output logic [1:0]           TargetDirect,
    output logic [NUM_FLOOR:1]   CarLamp,
    output logic [NUM_FLOOR-1:1] UpLamp,
    output logic [NUM_FLOOR:2]   DnLamp
);

    logic [NUM_FLOOR:1]   car_q;
    logic [NUM_FLOOR-1:1] up_q;
    logic [NUM_FLOOR:2]   dn_q;
    logic [NUM_FLOOR:1]   car_clr;
    logic [NUM_FLOOR-1:1] up_clr;
    logic [NUM_FLOOR:2]   dn_clr;
    logic [NUM_FLOOR:1]   up_w;
    logic [NUM_FLOOR:1]   dn_w;

    sweep_t state_q;
    sweep_t state_d;

    logic               floor_ok;
    logic               serve;
    logic               any_above;
    logic               any_below;
    logic               any_here;
    logic [FLOOR_W-1:0] next_floor;
    logic [1:0]         next_dir;

    assign floor_ok = (FloorIn != FLOOR_NONE) && (int'(FloorIn) <= NUM_FLOOR);
    assign serve    = (DoorIn == OPEN) && floor_ok;

    // No up call at the top floor, no down call at the bottom.
    assign up_w = {1'b0, up_q};
    assign dn_w = {dn_q, 1'b0};

    assign CarLamp = car_q;
    assign UpLamp  = up_q;
    assign DnLamp  = dn_q;

    elevator_call_pick u_pick (
        .car        (car_q),
        .up         (up_w),
        .dn         (dn_w),
        .floor_in   (FloorIn),
        .state      (state_q),
        .any_above  (any_above),
        .any_below  (any_below),
        .any_here   (any_here),
        .next_floor (next_floor),
        .next_dir   (next_dir)
    );

    // A hall call in the opposite direction is only retired here
    // when the sweep has nothing left to do past this floor.
    always_comb begin
        car_clr = '0;
        up_clr  = '0;
        dn_clr  = '0;
        if (serve) begin
            for (int i = 1; i <= NUM_FLOOR; i++)
                if (int'(FloorIn) == i)
                    car_clr[i] = 1'b1;
            for (int i = 1; i < NUM_FLOOR; i++)
                if (int'(FloorIn) == i && (state_q != DOWN || !any_below))
                    up_clr[i] = 1'b1;
            for (int i = 2; i <= NUM_FLOOR; i++)
                if (int'(FloorIn) == i && (state_q != UP || !any_above))
                    dn_clr[i] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            car_q <= '0;
            up_q  <= '0;
            dn_q  <= '0;
        end else begin
            car_q <= (car_q | CarBtn) & ~car_clr;
            up_q  <= (up_q | HallUpBtn) & ~up_clr;
            dn_q  <= (dn_q | HallDnBtn) & ~dn_clr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (floor_ok) begin
            unique case (state_q)
                IDLE:
                    if (any_above || any_below)
                        state_d = (next_dir == DIR_UP) ? UP : DOWN;
                UP:
                    if (next_floor == FLOOR_NONE)
                        state_d = any_below ? DOWN : IDLE;
                DOWN:
                    if (next_floor == FLOOR_NONE)
                        state_d = any_above ? UP : IDLE;
                default:
                    state_d = IDLE;
            endcase
        end
    end

    // Outputs freeze while the floor code is invalid.
    always_ff @(posedge clk) begin
        if (reset) begin
            TargetFloor  <= FLOOR_NONE;
            TargetDirect <= DIR_NONE;
        end else if (floor_ok) begin
            TargetFloor <= next_floor;
            if (state_q == IDLE || next_floor == FLOOR_NONE)
                TargetDirect <= DIR_NONE;
            else
                TargetDirect <= next_dir;
        end
    end

    a_dir_consistent: assert property (
        @(posedge clk) disable iff (reset)
        !(((state_q == UP) && (DirectIn == DIR_DN)) ||
          ((state_q == DOWN) && (DirectIn == DIR_UP))) ||
        (TargetFloor == FLOOR_NONE)
    );

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// Directed bench for elevator_call_scheduler.
// Hand-computed expectations for latching, SCAN targets, clears and reset.
module tb_elevator_call_scheduler;

    logic       clk;
    logic       reset;
    logic [7:1] CarBtn;
    logic [6:1] HallUpBtn;
    logic [7:2] HallDnBtn;
    logic [2:0] FloorIn;
    logic [1:0] DirectIn;
    logic       DoorIn;
    logic [2:0] TargetFloor;
    logic [1:0] TargetDirect;
    logic [7:1] CarLamp;
    logic [6:1] UpLamp;
    logic [7:2] DnLamp;

    int n_vec;
    int n_err;

    elevator_call_scheduler dut (
        .clk          (clk),
        .reset        (reset),
        .CarBtn       (CarBtn),
        .HallUpBtn    (HallUpBtn),
        .HallDnBtn    (HallDnBtn),
        .FloorIn      (FloorIn),
        .DirectIn     (DirectIn),
        .DoorIn       (DoorIn),
        .TargetFloor  (TargetFloor),
        .TargetDirect (TargetDirect),
        .CarLamp      (CarLamp),
        .UpLamp       (UpLamp),
        .DnLamp       (DnLamp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        reset     = 1'b1;
        CarBtn    = '0;
        HallUpBtn = '0;
        HallDnBtn = '0;
        FloorIn   = 3'd1;
        DirectIn  = 2'b00;
        DoorIn    = 1'b0;
        step();
        step();
        chk("rst_tf",  8'(TargetFloor),  8'd0);
        chk("rst_td",  8'(TargetDirect), 8'd0);
        chk("rst_car", 8'(CarLamp),      8'h00);
        chk("rst_up",  8'(UpLamp),       8'h00);
        chk("rst_dn",  8'(DnLamp),       8'h00);
        reset = 1'b0;
        step();

        // car call at 5 from floor 1
        CarBtn = 7'h10;
        step();
        CarBtn = '0;
        chk("t1_lamp",  8'(CarLamp),      8'h10);
        chk("t1_tf_n1", 8'(TargetFloor),  8'd0);
        step();
        chk("t1_tf_n2", 8'(TargetFloor),  8'd5);
        chk("t1_td_n2", 8'(TargetDirect), 8'd0);
        step();
        chk("t1_tf_n3", 8'(TargetFloor),  8'd5);
        chk("t1_td_n3", 8'(TargetDirect), 8'h02);

        // serve floor 5
        FloorIn = 3'd5;
        DoorIn  = 1'b1;
        step();
        chk("t2_lamp", 8'(CarLamp),      8'h00);
        chk("t2_hold", 8'(TargetFloor),  8'd5);
        step();
        chk("t2_tf",   8'(TargetFloor),  8'd0);
        chk("t2_td",   8'(TargetDirect), 8'd0);
        DoorIn = 1'b0;
        step();

        // car 6 and hall dn 4 from floor 3
        FloorIn   = 3'd3;
        CarBtn    = 7'h20;
        HallDnBtn = 6'h04;
        step();
        CarBtn    = '0;
        HallDnBtn = '0;
        chk("t3_car",   8'(CarLamp),      8'h20);
        chk("t3_dn",    8'(DnLamp),       8'h04);
        step();
        chk("t3_idle",  8'(TargetFloor),  8'd4);
        chk("t3_idtd",  8'(TargetDirect), 8'd0);
        step();
        chk("t3_tf6",   8'(TargetFloor),  8'd6);
        chk("t3_td6",   8'(TargetDirect), 8'h02);
        FloorIn = 3'd6;
        DoorIn  = 1'b1;
        step();
        chk("t3_car6",  8'(CarLamp),      8'h00);
        chk("t3_dnkp",  8'(DnLamp),       8'h04);
        chk("t3_hold6", 8'(TargetFloor),  8'd6);
        step();
        chk("t3_turn",  8'(TargetFloor),  8'd0);
        step();
        chk("t3_tf4",   8'(TargetFloor),  8'd4);
        chk("t3_td4",   8'(TargetDirect), 8'h01);
        DoorIn  = 1'b0;
        FloorIn = 3'd4;
        DoorIn  = 1'b1;
        step();
        chk("t3_dn4",   8'(DnLamp),       8'h00);
        chk("t3_hold4", 8'(TargetFloor),  8'd4);
        step();
        chk("t3_empty", 8'(TargetFloor),  8'd0);
        DoorIn = 1'b0;
        step();

        // tie from floor 4: up 2 and car 6
        HallUpBtn = 6'h02;
        CarBtn    = 7'h20;
        step();
        HallUpBtn = '0;
        CarBtn    = '0;
        chk("t4_up",   8'(UpLamp),       8'h02);
        chk("t4_car",  8'(CarLamp),      8'h20);
        step();
        chk("t4_tf",   8'(TargetFloor),  8'd6);
        chk("t4_td0",  8'(TargetDirect), 8'd0);
        step();
        chk("t4_tfu",  8'(TargetFloor),  8'd6);
        chk("t4_tdu",  8'(TargetDirect), 8'h02);

        // clear beats set at floor 3 going up
        FloorIn   = 3'd3;
        DoorIn    = 1'b1;
        HallUpBtn = 6'h04;
        step();
        chk("t5_up_a", 8'(UpLamp),      8'h02);
        chk("t5_tf",   8'(TargetFloor), 8'd6);
        step();
        chk("t5_up_b", 8'(UpLamp),      8'h02);
        HallUpBtn = '0;
        step();
        chk("t5_up_c", 8'(UpLamp),      8'h02);
        DoorIn = 1'b0;
        step();
        chk("t5_up_d", 8'(UpLamp),       8'h02);
        chk("t5_td",   8'(TargetDirect), 8'h02);

        // invalid floor: hold outputs, allow sets, no clears
        FloorIn   = 3'd0;
        DoorIn    = 1'b1;
        HallDnBtn = 6'h08;
        step();
        HallDnBtn = '0;
        chk("t6_dn", 8'(DnLamp), 8'h08);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t6_tf",  8'(TargetFloor),  8'd6);
            chk("t6_td",  8'(TargetDirect), 8'h02);
            chk("t6_car", 8'(CarLamp),      8'h20);
        end
        chk("t6_up", 8'(UpLamp), 8'h02);

        // mid-sweep reset with a held button
        reset   = 1'b1;
        DoorIn  = 1'b0;
        FloorIn = 3'd2;
        CarBtn  = 7'h02;
        step();
        chk("t6_rcar", 8'(CarLamp),      8'h00);
        chk("t6_rup",  8'(UpLamp),       8'h00);
        chk("t6_rdn",  8'(DnLamp),       8'h00);
        chk("t6_rtf",  8'(TargetFloor),  8'd0);
        chk("t6_rtd",  8'(TargetDirect), 8'd0);
        reset = 1'b0;
        step();
        chk("t6_relat", 8'(CarLamp), 8'h02);
        CarBtn = '0;
        step();
        chk("t7_here",  8'(TargetFloor),  8'd2);
        chk("t7_htd",   8'(TargetDirect), 8'd0);
        DoorIn = 1'b1;
        step();
        chk("t7_clr",   8'(CarLamp),     8'h00);
        chk("t7_hold",  8'(TargetFloor), 8'd2);
        step();
        chk("t7_none",  8'(TargetFloor), 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
